// File: rtl/sam_vram_pkg.sv
// Shared types for the VRAM arbiter: issue-slot states, return tags and
// the per-access info that rides alongside the memory read latency.
package sam_vram_pkg;
    localparam int VRAM_ADDR_W = 19;
    localparam int MEM_LAT     = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        V1   = 2'd1,
        V2   = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID1 = 2'd1,
        TAG_VID2 = 2'd2,
        TAG_CPU  = 2'd3
    } slot_tag_t;

    // Return-path routing for one issued access.
    typedef struct packed {
        slot_tag_t tag;
        logic      lane;  // CPU byte lane, 1 = high byte
        logic      rd;    // CPU access is a read
    } slot_info_t;
endpackage

// File: rtl/vram_arbiter.sv
// VRAM arbiter: one memory slot per cycle shared between a two-word video
// fetch (always wins) and single-byte CPU accesses that fill idle slots.
module vram_arbiter
    import sam_vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr1,
    input  logic [ADDR_W-1:0] vid_addr2,
    output logic [15:0]       vid_dout1,
    output logic [15:0]       vid_dout2,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_busy,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    input  logic [15:0]       mem_q
);
    slot_state_t       state, state_nxt;
    logic [ADDR_W-2:0] vid_word2_q;
    logic              cpu_pend, cpu_we_q;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [7:0]        cpu_din_q;
    logic              vid_take, cpu_cap, cpu_issue;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [7:0]        eff_din;
    slot_info_t        bus_info;
    slot_info_t        info_pipe [MEM_LAT];
    slot_info_t        ret_info;
    logic              unused_addr_lsb;

    // Video addresses are word addresses on the bus; the byte bit is dropped.
    assign unused_addr_lsb = vid_addr1[0] ^ vid_addr2[0];

    // A fetch is accepted anywhere except while its first word is issuing.
    assign vid_take  = vid_req && (state != V1);
    assign cpu_cap   = cpu_req && !cpu_busy;
    // CPU takes the next slot only if video does not claim it; a request
    // captured this very edge may issue straight away from the inputs.
    assign cpu_issue = (cpu_cap || cpu_pend) && (state_nxt == IDLE);
    assign eff_we    = cpu_cap ? cpu_we   : cpu_we_q;
    assign eff_addr  = cpu_cap ? cpu_addr : cpu_addr_q;
    assign eff_din   = cpu_cap ? cpu_din  : cpu_din_q;
    assign ret_info  = info_pipe[MEM_LAT-1];

    // Slot state register: state names the access on the bus this cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next slot: a fetch occupies V1 then V2; V2 may chain into a new fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vid_take) state_nxt = V1;
            V1:      state_nxt = V2;
            V2:      state_nxt = vid_take ? V1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // CPU request capture, pending flag and busy flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_pend   <= 1'b0;
            cpu_busy   <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
        end else begin
            if (cpu_cap) begin
                cpu_we_q   <= cpu_we;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
            end
            cpu_pend <= (cpu_cap || cpu_pend) && !cpu_issue;
            if (cpu_cap)      cpu_busy <= 1'b1;
            else if (cpu_ack) cpu_busy <= 1'b0;
        end
    end

    // Registered memory command for the slot chosen above.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_we      <= 1'b0;
            mem_be      <= 2'b00;
            vid_word2_q <= '0;
            bus_info    <= '0;
        end else begin
            mem_we   <= 1'b0;
            mem_be   <= 2'b00;
            bus_info <= '0;
            if (vid_take) vid_word2_q <= vid_addr2[ADDR_W-1:1];
            if (state_nxt == V1) begin
                mem_addr <= vid_addr1[ADDR_W-1:1];
                mem_be   <= 2'b11;
                bus_info <= '{tag: TAG_VID1, lane: 1'b0, rd: 1'b0};
            end else if (state_nxt == V2) begin
                mem_addr <= vid_word2_q;
                mem_be   <= 2'b11;
                bus_info <= '{tag: TAG_VID2, lane: 1'b0, rd: 1'b0};
            end else if (cpu_issue) begin
                mem_addr <= eff_addr[ADDR_W-1:1];
                mem_we   <= eff_we;
                mem_be   <= eff_addr[0] ? 2'b10 : 2'b01;
                mem_din  <= {eff_din, eff_din};
                bus_info <= '{tag: TAG_CPU, lane: eff_addr[0], rd: !eff_we};
            end
        end
    end

    // Delay routing info by the memory latency so it lines up with mem_q.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) info_pipe[i] <= '0;
        end else begin
            info_pipe[0] <= bus_info;
            for (int i = 1; i < MEM_LAT; i++) info_pipe[i] <= info_pipe[i-1];
        end
    end

    // Route returning read data to its owner and raise completion pulses.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_dout1 <= '0;
            vid_dout2 <= '0;
            vid_valid <= 1'b0;
            cpu_dout  <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            case (ret_info.tag)
                TAG_VID1: vid_dout1 <= mem_q;
                TAG_VID2: begin
                    vid_dout2 <= mem_q;
                    vid_valid <= 1'b1;
                end
                TAG_CPU: begin
                    cpu_ack <= 1'b1;
                    if (ret_info.rd) cpu_dout <= ret_info.lane ? mem_q[15:8] : mem_q[7:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a slot-level reference model predicts
// bus accesses, video pairs and CPU completions; a monitor compares them.
module tb_vram_arbiter;
    import sam_vram_pkg::*;
    localparam int AW    = VRAM_ADDR_W;
    localparam int WORDS = 1 << (AW - 1);

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr1 = '0, vid_addr2 = '0;
    logic [15:0]   vid_dout1, vid_dout2;
    logic          vid_valid;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic [7:0]    cpu_dout;
    logic          cpu_ack, cpu_busy;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [15:0]   mem_q = '0;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int vv_cnt = 0;

    vram_arbiter #(.ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr1(vid_addr1), .vid_addr2(vid_addr2),
        .vid_dout1(vid_dout1), .vid_dout2(vid_dout2), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_be(mem_be),
        .mem_q(mem_q)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Memory behind the DUT: registered read, byte-enabled write.
    logic [15:0] ram    [WORDS];
    logic [15:0] shadow [WORDS];
    always @(posedge clk_sys) begin
        mem_q <= ram[mem_addr];
        if (mem_we) begin
            if (mem_be[0]) ram[mem_addr][7:0]  <= mem_din[7:0];
            if (mem_be[1]) ram[mem_addr][15:8] <= mem_din[15:8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            cyc;
        int            kind;   // 1 first video word, 2 second video word, 3 cpu
        logic [AW-2:0] addr;
        logic          we;
        logic [1:0]    be;
        logic [15:0]   din;
    } acc_t;
    typedef struct { int cyc; logic [15:0] w1; logic [15:0] w2; } vexp_t;
    typedef struct { int cyc; logic [7:0] dout; } cexp_t;

    acc_t  sched[$];   // model-owned slot plan
    acc_t  bus_q[$];   // same plan, consumed by the monitor
    vexp_t vid_q[$];
    cexp_t ack_q[$];
    logic          m_busy = 1'b0, m_pend = 1'b0, p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [7:0]    p_din = '0, last_dout = '0;
    logic [15:0]   m_w1 = '0;
    int            busy_clr = -1;

    function automatic bit slot_taken(input int c);
        foreach (sched[i]) if (sched[i].cyc == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic plan(input acc_t a);
        sched.push_back(a);
        bus_q.push_back(a);
    endtask

    always @(posedge clk_sys) begin
        int   n;
        bit   in_first;
        acc_t s;
        n = cyc;
        in_first = 1'b0;
        // Carry out the access occupying the current slot.
        if (sched.size() > 0 && sched[0].cyc == n) begin
            s = sched.pop_front();
            case (s.kind)
                1: begin m_w1 = shadow[s.addr]; in_first = 1'b1; end
                2: vid_q.push_back('{cyc: n + 2, w1: m_w1, w2: shadow[s.addr]});
                default: begin
                    if (s.we) begin
                        if (s.be[0]) shadow[s.addr][7:0]  = s.din[7:0];
                        if (s.be[1]) shadow[s.addr][15:8] = s.din[15:8];
                    end else begin
                        last_dout = s.be[1] ? shadow[s.addr][15:8] : shadow[s.addr][7:0];
                    end
                    ack_q.push_back('{cyc: n + 2, dout: last_dout});
                    busy_clr = n + 2;
                end
            endcase
        end
        if (reset) begin
            sched.delete(); bus_q.delete(); vid_q.delete(); ack_q.delete();
            m_busy = 1'b0; m_pend = 1'b0; last_dout = '0; busy_clr = -1;
        end else begin
            if (vid_req && !in_first) begin
                plan('{cyc: n + 1, kind: 1, addr: (AW-1)'(vid_addr1 / 2), we: 1'b0, be: 2'b11, din: '0});
                plan('{cyc: n + 2, kind: 2, addr: (AW-1)'(vid_addr2 / 2), we: 1'b0, be: 2'b11, din: '0});
            end
            if (cpu_req && !m_busy) begin
                m_busy = 1'b1; m_pend = 1'b1;
                p_we = cpu_we; p_addr = cpu_addr; p_din = cpu_din;
            end
            if (m_pend && !slot_taken(n + 1)) begin
                plan('{cyc: n + 1, kind: 3, addr: (AW-1)'(p_addr / 2), we: p_we,
                       be: (p_addr % 2 == 1) ? 2'b10 : 2'b01, din: {p_din, p_din}});
                m_pend = 1'b0;
            end
            if (n == busy_clr) m_busy = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_sys) begin
        vexp_t ve;
        cexp_t ce;
        acc_t  be;
        if (vid_valid) begin
            vv_cnt++;
            if (vid_q.size() == 0) miss("vid_valid unexpected");
            else begin
                ve = vid_q.pop_front();
                chk("vid_valid cycle", cyc, ve.cyc);
                chk("vid_dout1", vid_dout1, ve.w1);
                chk("vid_dout2", vid_dout2, ve.w2);
            end
        end else if (vid_q.size() > 0 && vid_q[0].cyc <= cyc) begin
            void'(vid_q.pop_front());
            miss("vid_valid missing");
        end
        if (cpu_ack) begin
            if (ack_q.size() == 0) miss("cpu_ack unexpected");
            else begin
                ce = ack_q.pop_front();
                chk("cpu_ack cycle", cyc, ce.cyc);
                chk("cpu_dout", cpu_dout, ce.dout);
            end
        end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
            void'(ack_q.pop_front());
            miss("cpu_ack missing");
        end
        if (mem_be != 2'b00) begin
            if (bus_q.size() == 0) miss("bus access unexpected");
            else begin
                be = bus_q.pop_front();
                chk("bus cycle", cyc, be.cyc);
                chk("mem_addr", mem_addr, be.addr);
                chk("mem_we", mem_we, be.we);
                chk("mem_be", mem_be, be.be);
                if (be.kind == 3) chk("mem_din", mem_din, be.din);
            end
        end else begin
            chk("idle mem_we", mem_we, 1'b0);
            if (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
                void'(bus_q.pop_front());
                miss("bus access missing");
            end
        end
        chk("cpu_busy", cpu_busy, m_busy);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_vid(input string nm, output int at);
        at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            if (vid_valid) begin at = cyc; break; end
        end
        if (at < 0) miss({nm, " vid_valid timeout"});
    endtask

    task automatic wait_ack(input string nm, output int at);
        at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) begin at = cyc; break; end
        end
        if (at < 0) miss({nm, " cpu_ack timeout"});
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " vid_dout1"}, vid_dout1, 16'h0);
        chk({nm, " vid_dout2"}, vid_dout2, 16'h0);
        chk({nm, " vid_valid"}, vid_valid, 1'b0);
        chk({nm, " cpu_dout"}, cpu_dout, 8'h0);
        chk({nm, " cpu_ack"}, cpu_ack, 1'b0);
        chk({nm, " cpu_busy"}, cpu_busy, 1'b0);
        chk({nm, " mem_we"}, mem_we, 1'b0);
        chk({nm, " mem_be"}, mem_be, 2'b00);
        chk({nm, " mem_addr"}, mem_addr, 18'h0);
    endtask

    initial begin
        int n0, at, vv0;
        for (int i = 0; i < WORDS; i++) begin
            ram[i] = 16'($urandom);
            shadow[i] = ram[i];
        end
        repeat (3) step();
        @(negedge clk_sys);
        chk_reset_vals("reset");
        step();
        reset = 1'b0;

        // Directed fetch with known words.
        ram[18'h00080] = 16'h1234; shadow[18'h00080] = 16'h1234;
        ram[18'h01080] = 16'hBEEF; shadow[18'h01080] = 16'hBEEF;
        n0 = cyc;
        vid_req = 1'b1; vid_addr1 = 19'h00100; vid_addr2 = 19'h02100;
        step();
        vid_req = 1'b0; vid_addr1 = AW'($urandom); vid_addr2 = AW'($urandom);
        @(negedge clk_sys);
        chk("fetch word1 addr", mem_addr, 18'h00080);
        step();
        @(negedge clk_sys);
        chk("fetch word2 addr", mem_addr, 18'h01080);
        wait_vid("fetch", at);
        chk("fetch latency", at - n0, 4);
        chk("fetch dout1", vid_dout1, 16'h1234);
        chk("fetch dout2", vid_dout2, 16'hBEEF);
        step();

        // CPU write then read of the odd byte.
        n0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00001; cpu_din = 8'hA5;
        step();
        cpu_req = 1'b0;
        @(negedge clk_sys);
        chk("cpu wr be", mem_be, 2'b10);
        chk("cpu wr din", mem_din, 16'hA5A5);
        chk("cpu wr we", mem_we, 1'b1);
        wait_ack("cpu wr", at);
        chk("cpu wr ack latency", at - n0, 3);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00001;
        step();
        cpu_req = 1'b0;
        wait_ack("cpu rd", at);
        chk("cpu rd dout", cpu_dout, 8'hA5);
        step();

        // Simultaneous video and CPU; a second CPU request while busy.
        n0 = cyc;
        vid_req = 1'b1; vid_addr1 = AW'($urandom); vid_addr2 = AW'($urandom);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom);
        step();
        vid_req = 1'b0;
        cpu_we = 1'b1; cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
        step();
        cpu_req = 1'b0;
        wait_ack("contend", at);
        chk("contend ack latency", at - n0, 5);
        repeat (6) step();

        // Back-to-back fetches every two cycles.
        vv0 = vv_cnt;
        for (int i = 0; i < 64; i++) begin
            vid_req = 1'b1; vid_addr1 = AW'($urandom); vid_addr2 = AW'($urandom);
            step();
            vid_req = 1'b0;
            step();
        end
        repeat (6) step();
        chk("stream fetch count", vv_cnt - vv0, 64);

        // Reset while a fetch and a CPU write are in flight.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
        step();
        cpu_req = 1'b0;
        vid_req = 1'b1; vid_addr1 = AW'($urandom); vid_addr2 = AW'($urandom);
        step();
        vid_req = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk_sys);
        chk_reset_vals("mid-op reset");
        step();
        n0 = cyc;
        vid_req = 1'b1; vid_addr1 = AW'($urandom); vid_addr2 = AW'($urandom);
        step();
        vid_req = 1'b0;
        wait_vid("after reset", at);
        chk("after reset latency", at - n0, 4);
        step();

        // Randomized mix, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            vid_req   = ($urandom_range(0, 2) == 0);
            vid_addr1 = AW'($urandom); vid_addr2 = AW'($urandom);
            cpu_req   = ($urandom_range(0, 3) == 0);
            cpu_we    = 1'($urandom); cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end
        vid_req = 1'b0; cpu_req = 1'b0; reset = 1'b0;
        repeat (20) step();
        chk("video queue drained", vid_q.size(), 0);
        chk("ack queue drained", ack_q.size(), 0);
        chk("bus queue drained", bus_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
